spike_event_logger: RTL and testbench

- Sits directly downstream of the LIF neuron.
- On each rising edge of the neuron's spike output, captures a timestamp and the membrane state value and pushes them as one event into a small FIFO.
- Events drain through a valid/ready port to the host or readout logic.
- Also provides a sticky overflow flag and a live occupancy count.

---
 rtl/snn_pkg.sv | 13 +
 rtl/sync_fifo.sv | 74 +++++++
 rtl/spike_event_logger.sv | 98 +++++++++
 tb/tb_spike_event_logger.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron readout blocks.
package snn_pkg;

    localparam int TS_WIDTH_DEF    = 8;
    localparam int STATE_WIDTH_DEF = 8;

    // One logged spike event, timestamp in the upper bits.
    typedef struct packed {
        logic [TS_WIDTH_DEF-1:0]    ts;
        logic [STATE_WIDTH_DEF-1:0] state;
    } spike_evt_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and full/empty flags.
// The read port is combinational from the head entry, so a word written in
// cycle N first appears at o_rdata in cycle N+1 (no fall-through).
module sync_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [WIDTH-1:0]      i_wdata,
    output logic [WIDTH-1:0]      o_rdata,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == (ADDR_WIDTH+1)'(DEPTH));
    assign o_empty = (r_count == '0);

    // Pops from an empty FIFO are ignored; a push into a full FIFO is only
    // taken when a pop frees the slot in the same cycle.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    // Storage is not reset; stale contents are hidden by the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/spike_event_logger.sv
// Logs {timestamp, membrane state} on each enabled rising edge of the neuron
// spike into a small FIFO drained by a valid/ready consumer. A sticky flag
// records any event dropped because the FIFO was full.
module spike_event_logger
    import snn_pkg::*;
#(
    parameter int TS_WIDTH    = TS_WIDTH_DEF,
    parameter int STATE_WIDTH = STATE_WIDTH_DEF,
    parameter int DEPTH       = 8,
    parameter int ADDR_WIDTH  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   spike,
    input  logic [STATE_WIDTH-1:0] state,
    input  logic                   clr_ovf,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TS_WIDTH-1:0]    out_ts,
    output logic [STATE_WIDTH-1:0] out_state,
    output logic [ADDR_WIDTH:0]    count,
    output logic                   overflow
);

    localparam int EVT_WIDTH = TS_WIDTH + STATE_WIDTH;

    logic [TS_WIDTH-1:0]  r_ts;
    logic                 r_spike_q;
    logic                 r_overflow;

    logic                 w_evt;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_full;
    logic                 w_empty;
    logic [EVT_WIDTH-1:0] w_wdata;
    logic [EVT_WIDTH-1:0] w_rdata;
    logic [ADDR_WIDTH:0]  w_count;

    // Free-running timestamp, frozen while logging is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts <= '0;
        end else if (enable) begin
            r_ts <= r_ts + TS_WIDTH'(1);
        end
    end

    // Spike history tracks the input even while disabled, so an edge that
    // happened during disable is not replayed when enable returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spike_q <= 1'b0;
        end else begin
            r_spike_q <= spike;
        end
    end

    assign w_evt   = spike & ~r_spike_q & enable;
    assign w_pop   = ~w_empty & out_ready;
    assign w_drop  = w_evt & w_full & ~w_pop;
    // Timestamp captured is the pre-increment value of the event cycle.
    assign w_wdata = {r_ts, state};

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH      (EVT_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_evt),
        .i_pop   (out_ready),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid             = ~w_empty;
    assign {out_ts, out_state}   = w_rdata;
    assign count                 = w_count;
    assign overflow              = r_overflow;

endmodule

// File: tb/tb_spike_event_logger.sv
// Directed bench for spike_event_logger: one task per scenario.
module tb_spike_event_logger;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       spike;
    logic [7:0] state;
    logic       clr_ovf;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_ts;
    logic [7:0] out_state;
    logic [3:0] count;
    logic       overflow;

    int total;
    int bad;

    spike_event_logger dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .spike     (spike),
        .state     (state),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ts    (out_ts),
        .out_state (out_state),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        enable    = 1'b1;
        spike     = 1'b0;
        state     = 8'h00;
        clr_ovf   = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pulse(input logic [7:0] st);
        state = st;
        spike = 1'b1;
        tick();
        spike = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0d exp=0", out_valid); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%0d exp=0", overflow); end
        rst_n = 1'b1;
        repeat (10) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%0d exp=0", out_valid); end
        // ts is now 10; the next edge logs it.
        pulse(8'h01);
        total++; if (out_ts !== 8'd10) begin bad++; $display("FAIL idle_ts got=%0d exp=10", out_ts); end
        $display("test_reset done: ts observed=%0d", out_ts);
    endtask

    task automatic test_single_held();
        do_reset();
        rst_n = 1'b1;
        repeat (4) tick();
        state = 8'h83;
        spike = 1'b1;
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0d exp=1", out_valid); end
        total++; if (out_ts !== 8'd4) begin bad++; $display("FAIL single_ts got=%0d exp=4", out_ts); end
        total++; if (out_state !== 8'h83) begin bad++; $display("FAIL single_state got=%h exp=83", out_state); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
        state = 8'h55;
        repeat (4) tick();
        spike = 1'b0;
        total++; if (count !== 4'd1) begin bad++; $display("FAIL held_count got=%0d exp=1", count); end
        total++; if (out_state !== 8'h83) begin bad++; $display("FAIL held_state got=%h exp=83", out_state); end
        pop_one();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL single_pop_count got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%0d exp=0", out_valid); end
        $display("test_single_held done");
    endtask

    task automatic test_overflow();
        logic [7:0] exp_ts;
        do_reset();
        rst_n = 1'b1;
        // Edges at ts 0,2,...,16; the ninth is dropped.
        for (int i = 0; i < 9; i++) pulse(8'(i));
        total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0d exp=1", overflow); end
        // Clear coinciding with another drop: set wins.
        state   = 8'hEE;
        spike   = 1'b1;
        clr_ovf = 1'b1;
        tick();
        spike   = 1'b0;
        clr_ovf = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_clr_vs_drop got=%0d exp=1", overflow); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count2 got=%0d exp=8", count); end
        for (int i = 0; i < 8; i++) begin
            exp_ts = 8'(2 * i);
            total++; if (out_ts !== exp_ts) begin bad++; $display("FAIL ovf_rd_ts[%0d] got=%0d exp=%0d", i, out_ts, exp_ts); end
            total++; if (out_state !== 8'(i)) begin bad++; $display("FAIL ovf_rd_state[%0d] got=%0d exp=%0d", i, out_state, i); end
            pop_one();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%0d exp=0", out_valid); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0d exp=1", overflow); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0d exp=0", overflow); end
        $display("test_overflow done");
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_ts;
        logic [7:0] exp_st;
        do_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) pulse(8'(8'h10 + i));
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fpp_fill got=%0d exp=8", count); end
        // ts is 16 here; push and pop land in the same cycle.
        state     = 8'hAA;
        spike     = 1'b1;
        out_ready = 1'b1;
        tick();
        spike     = 1'b0;
        out_ready = 1'b0;
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fpp_count got=%0d exp=8", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf got=%0d exp=0", overflow); end
        for (int i = 1; i <= 8; i++) begin
            exp_ts = 8'(2 * i);
            exp_st = (i == 8) ? 8'hAA : 8'(8'h10 + i);
            total++; if (out_ts !== exp_ts) begin bad++; $display("FAIL fpp_ts[%0d] got=%0d exp=%0d", i, out_ts, exp_ts); end
            total++; if (out_state !== exp_st) begin bad++; $display("FAIL fpp_state[%0d] got=%h exp=%h", i, out_state, exp_st); end
            pop_one();
        end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL fpp_drain got=%0d exp=0", count); end
        $display("test_full_push_pop done");
    endtask

    task automatic test_ts_wrap();
        do_reset();
        rst_n = 1'b1;
        repeat (254) tick();
        state = 8'h11;
        spike = 1'b1;
        tick();          // logs ts=254
        spike = 1'b0;
        tick();          // ts 255 -> 0
        tick();          // ts 0 -> 1
        state = 8'h22;
        spike = 1'b1;
        tick();          // logs ts=1
        spike = 1'b0;
        total++; if (count !== 4'd2) begin bad++; $display("FAIL wrap_count got=%0d exp=2", count); end
        total++; if (out_ts !== 8'd254) begin bad++; $display("FAIL wrap_ts0 got=%0d exp=254", out_ts); end
        pop_one();
        total++; if (out_ts !== 8'd1) begin bad++; $display("FAIL wrap_ts1 got=%0d exp=1", out_ts); end
        total++; if (out_state !== 8'h22) begin bad++; $display("FAIL wrap_state1 got=%h exp=22", out_state); end
        $display("test_ts_wrap done");
    endtask

    task automatic test_reset_and_gate();
        do_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) pulse(8'(8'h30 + i));
        total++; if (count !== 4'd3) begin bad++; $display("FAIL rg_count got=%0d exp=3", count); end
        // Asynchronous reset in the middle of a cycle.
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rg_async_valid got=%0d exp=0", out_valid); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rg_async_count got=%0d exp=0", count); end
        tick();
        rst_n  = 1'b1;
        enable = 1'b0;
        tick();
        tick();
        spike = 1'b1;
        state = 8'h77;
        tick();          // edge while disabled: lost
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rg_gated got=%0d exp=0", count); end
        enable = 1'b1;
        tick();          // spike still high: no event, ts -> 1
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rg_no_recover got=%0d exp=0", out_valid); end
        spike = 1'b0;
        tick();          // ts -> 2
        state = 8'h99;
        spike = 1'b1;
        tick();          // logs ts=2
        spike = 1'b0;
        total++; if (out_ts !== 8'd2) begin bad++; $display("FAIL rg_frozen_ts got=%0d exp=2", out_ts); end
        total++; if (out_state !== 8'h99) begin bad++; $display("FAIL rg_state got=%h exp=99", out_state); end
        $display("test_reset_and_gate done");
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        enable    = 1'b1;
        spike     = 1'b0;
        state     = 8'h00;
        clr_ovf   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_single_held();
        test_overflow();
        test_full_push_pop();
        test_ts_wrap();
        test_reset_and_gate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
